// File: rtl/alu_pkg.sv
// Shared ALU definitions for the EX stage.
// Holds the 5-bit ALU control codes used by the ALU control decoder and the
// multiply sequencer, the sequencer state type, and a small decode helper.
package alu_pkg;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_AND    = 5'b00010;
    localparam logic [4:0] ALU_OR     = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_LUI    = 5'b01010;
    localparam logic [4:0] ALU_MUL    = 5'b10001;
    localparam logic [4:0] ALU_MULH   = 5'b10010;
    localparam logic [4:0] ALU_MULHSU = 5'b10011;
    localparam logic [4:0] ALU_MULHU  = 5'b10100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_e;

    // True for the four multiply codes handled by the sequencer.
    function automatic logic is_mul_op(input logic [4:0] code);
        return (code == ALU_MUL) || (code == ALU_MULH) ||
               (code == ALU_MULHSU) || (code == ALU_MULHU);
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_pp_step.sv
// mul_pp_step: combinational partial-product generator.
// Multiplies the XLEN-bit unsigned magnitude of operand A by one BPC-bit
// digit of operand B.
// Ports:
//   a_mag  in   XLEN       unsigned magnitude of A
//   digit  in   BPC        current multiplier digit
//   pp     out  XLEN+BPC   partial product (cannot overflow)
module mul_pp_step #(
    parameter int XLEN = 32,
    parameter int BPC  = 2
) (
    input  logic [XLEN-1:0]     a_mag,
    input  logic [BPC-1:0]      digit,
    output logic [XLEN+BPC-1:0] pp
);

    always_comb begin
        pp = (XLEN+BPC)'(a_mag) * (XLEN+BPC)'(digit);
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle sequencer for MUL/MULH/MULHSU/MULHU.
// Captures operands on start, retires BPC multiplier bits per cycle with a
// shift-add, applies the sign fixup, and stalls the pipeline until done.
// Ports:
//   clk       in   1     clock (rising edge)
//   rst       in   1     synchronous active-high reset
//   start     in   1     EX presents a valid op
//   alu_ctrl  in   5     ALU control code (only multiply codes are accepted)
//   op_a      in   XLEN  rs1
//   op_b      in   XLEN  rs2
//   flush     in   1     kill the in-flight op
//   stall     out  1     hold IF/ID/EX
//   done      out  1     one-cycle result-valid pulse
//   result    out  XLEN  product slice, held until the next completed op
module mul_seq_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N_ITER = XLEN / BPC;
    localparam int CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int ACC_W  = 2 * XLEN;
    localparam int SW     = $clog2(ACC_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_ITER - 1);

    mul_state_e state, state_nx;

    logic [XLEN-1:0]     a_mag, b_mag;
    logic [CW-1:0]       cnt;
    logic [ACC_W-1:0]    acc;
    logic                neg;
    logic                low_half;

    logic                accept;
    logic                a_neg_in, b_neg_in;
    logic [XLEN-1:0]     a_abs, b_abs;
    logic                zero_op;
    logic [XLEN+BPC-1:0] pp;
    logic [SW-1:0]       shamt;
    logic [ACC_W-1:0]    acc_fix;

    mul_pp_step #(.XLEN(XLEN), .BPC(BPC)) u_pp (
        .a_mag (a_mag),
        .digit (b_mag[BPC-1:0]),
        .pp    (pp)
    );

    always_comb begin
        accept   = (state == IDLE) && start && !flush && is_mul_op(alu_ctrl);
        a_neg_in = ((alu_ctrl == ALU_MULH) || (alu_ctrl == ALU_MULHSU)) && op_a[XLEN-1];
        b_neg_in = (alu_ctrl == ALU_MULH) && op_b[XLEN-1];
        // XLEN-bit negation leaves 0x80..0 as itself, which is the correct unsigned magnitude.
        a_abs    = a_neg_in ? (~op_a + 1'b1) : op_a;
        b_abs    = b_neg_in ? (~op_b + 1'b1) : op_b;
        zero_op  = (a_abs == '0) || (b_abs == '0);
        shamt    = SW'(cnt) * SW'(BPC);
        acc_fix  = neg ? (~acc + 1'b1) : acc;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    stall = 1'b1;
                    // Zero operands skip CALC but still pass through FIX,
                    // giving a fixed two-cycle fast path.
                    state_nx = zero_op ? FIX : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (flush)
                    state_nx = IDLE;
                else if (cnt == CNT_LAST)
                    state_nx = FIX;
            end
            FIX: begin
                stall    = 1'b1;
                state_nx = flush ? IDLE : DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_mag    <= '0;
            b_mag    <= '0;
            cnt      <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            low_half <= 1'b0;
            result   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_mag    <= a_abs;
                        b_mag    <= b_abs;
                        cnt      <= '0;
                        acc      <= '0;
                        neg      <= zero_op ? 1'b0 : (a_neg_in ^ b_neg_in);
                        low_half <= (alu_ctrl == ALU_MUL);
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc   <= acc + (ACC_W'(pp) << shamt);
                        b_mag <= b_mag >> BPC;
                        cnt   <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!flush)
                        result <= low_half ? acc_fix[XLEN-1:0] : acc_fix[ACC_W-1:XLEN];
                end
                default: ;
            endcase
        end
    end

endmodule
